trace_buf: RTL and testbench
============================

# trace_buf

Commit-trace buffer that sits directly downstream of the single-cycle `mips` top. Each cycle it captures the retiring instruction's record (`pc_now`, `str_now`, `if_reg`, `if_mem`) into a parameterised FIFO and drains it through a valid/ready port to a trace consumer (bench logger or UART bridge). The CPU cannot stall, so on overflow the buffer drops records and accounts for them instead of back-pressuring.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥2.
- `CNT_W`, 16: width of the dropped-record counter.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `cap_en` in 1: a record is offered this cycle (CPU retiring an instruction).
- `pc_now` in 32: PC of the retiring instruction.
- `str_now` in 32: instruction word.
- `if_reg` in 1: instruction writes GRF.
- `if_mem` in 1: instruction writes DM.
- `out_valid` out 1: head record available.
- `out_ready` in 1: consumer accepts the head record.
- `out_pc` out 32: head record PC; 0 when `out_valid`=0.
- `out_instr` out 32: head record instruction; 0 when `out_valid`=0.
- `out_flags` out 2: {if_mem, if_reg} of head; 0 when `out_valid`=0.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set on the first dropped record.
- `drop_cnt` out CNT_W: number of dropped records, saturating at all-ones.

## Operation
- Record = {pc, instr, if_mem, if_reg}, 66 bits.
- Push: `cap_en`=1 (and the record passes the filter, see Configuration) and not full after this cycle's pop → written at `wr_ptr`, `wr_ptr`++.
- Pop: `out_valid`=1 and `out_ready`=1 → `rd_ptr`++.
- Full with simultaneous pop and push: both happen; `level` stays DEPTH; no drop.
- Full with push and no pop: record discarded, `overflow`←1, `drop_cnt`++ unless already all-ones.
- Empty: `out_valid`=0; `out_ready` is ignored; a push into an empty buffer is not bypassed.
- Pointers are `$clog2(DEPTH)+1` bits wide and wrap naturally. Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal. `level` = `wr_ptr` − `rd_ptr`.
- Output ordering is strictly FIFO; records are never reordered or merged.
- Storage contents are not reset. `out_*` data is forced to 0 whenever `out_valid`=0.

## Timing
- Reset (asynchronous, active-low):
  - Pointers are 0.
  - `out_valid`=0, `out_pc`=0, `out_instr`=0, `out_flags`=0.
  - `level`=0, `overflow`=0, `drop_cnt`=0.
- Assertion mid-operation discards all queued records immediately; nothing drains after release.
- Latency: a record pushed at edge N is presented with `out_valid`=1 after edge N. Minimum capture-to-output is one cycle.
- Throughput: one push and one pop per cycle, sustained.
- Handshake:
  - While `out_valid`=1 and `out_ready`=0, the head record and `out_valid` hold stable.
  - `out_valid` never deasserts without a pop or reset.
  - `out_ready` may be asserted while `out_valid`=0.
- `level`, `overflow`, and `drop_cnt` are registered and update on the same edge as the push/pop that changes them.

## Configuration
- `TRACE_FILTER_EN` defined: only records with `if_reg`|`if_mem`=1 are pushed. Records with both flags 0 (branches, `j`, nops, stores-free non-writing ops) are silently skipped; they are not counted as drops.
- `TRACE_FILTER_EN` undefined: every `cap_en` cycle pushes a record.

## Structure
- Shared package `trace_pkg`:
  - `trace_rec_t` packed struct {pc[31:0], instr[31:0], if_mem, if_reg}.
  - Constant `TRACE_REC_W`=66.
  - Flag bit positions `FLAG_REG`=0, `FLAG_MEM`=1.
- One sub-module `trace_fifo_mem`: DEPTH×66 register array with a write port and a combinational read port. Pointer, flag, and counter logic stay in `trace_buf`.

## Test plan
- Reset, then push pc=0x3000/instr=0x34010001/flags=01 with `out_ready`=0:
  - `out_valid`=1 one cycle later; fields match; `level`=1.
  - Record holds for 5 stall cycles.
- Push 16 records (pc 0x3000..0x303C) with `out_ready`=0, then a 17th (pc 0x3040):
  - `level`=16, `overflow`=1, `drop_cnt`=1.
  - Draining yields 0x3000..0x303C in order; 0x3040 is absent.
- Fill to 16, then assert push+pop in the same cycle for 10 cycles:
  - `level` stays 16, `drop_cnt` stays 0.
  - Output sequence is contiguous.
- Push 3 records, assert `reset`=0 asynchronously mid-cycle:
  - `out_valid`, `level`, and outputs go to 0 without a clock edge.
  - After release, no stale records appear.
- With `CNT_W`=4, cause 20 drops:
  - `drop_cnt` saturates at 15.
  - `overflow` remains 1 until reset.
- With `TRACE_FILTER_EN`, push flags 00, 01, 10, 00:
  - Only the 01 and 10 records emerge, in order.
  - `drop_cnt`=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared record types and constants for the commit-trace buffer.
// The record filter is compiled in when TRACE_FILTER_EN is defined.
package trace_pkg;

    localparam int unsigned TRACE_REC_W = 66;
    localparam int unsigned FLAG_REG    = 0;
    localparam int unsigned FLAG_MEM    = 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        if_mem;
        logic        if_reg;
    } trace_rec_t;

    // Only state-changing instructions are worth tracing when filtering.
    function automatic logic rec_kept(input trace_rec_t rec);
        return rec.if_reg | rec.if_mem;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x TRACE_REC_W record storage: one write port, one combinational read port.
// Contents are deliberately not reset.
module trace_fifo_mem
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  trace_rec_t                 wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output trace_rec_t                 rdata
);

    logic [TRACE_REC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = trace_rec_t'(mem[raddr]);

endmodule

// File: rtl/trace_buf.sv
// Commit-trace FIFO: captures one retiring record per cycle, drains via valid/ready,
// and counts (never back-pressures) records dropped on overflow. Optional TRACE_FILTER_EN.
module trace_buf
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_en,
    input  logic [31:0]              pc_now,
    input  logic [31:0]              str_now,
    input  logic                     if_reg,
    input  logic                     if_mem,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [1:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    trace_rec_t    in_rec, rd_rec, head_nxt;
    logic          keep, full, pop, push, drop;

    always_comb begin
        in_rec        = '0;
        in_rec.pc     = pc_now;
        in_rec.instr  = str_now;
        in_rec.if_mem = if_mem;
        in_rec.if_reg = if_reg;
    end

`ifdef TRACE_FILTER_EN
    assign keep = rec_kept(in_rec);
`else
    assign keep = 1'b1;
`endif

    // Push/pop decisions and next head; a push into an empty buffer lands in the head register.
    always_comb begin
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = out_valid && out_ready;
        push       = cap_en && keep && (!full || pop);
        drop       = cap_en && keep && full && !pop;
        wr_ptr_nxt = wr_ptr + PW'(push);
        rd_ptr_nxt = rd_ptr + PW'(pop);
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        head_nxt   = '0;
        if (level_nxt != '0) begin
            head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? in_rec : rd_rec;
        end
    end

    trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_rec),
        .raddr (rd_ptr_nxt[AW-1:0]),
        .rdata (rd_rec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            out_flags <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            wr_ptr               <= wr_ptr_nxt;
            rd_ptr               <= rd_ptr_nxt;
            level                <= level_nxt;
            out_valid            <= (level_nxt != '0);
            out_pc               <= head_nxt.pc;
            out_instr            <= head_nxt.instr;
            out_flags[FLAG_MEM]  <= head_nxt.if_mem;
            out_flags[FLAG_REG]  <= head_nxt.if_reg;
            overflow             <= overflow | drop;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_trace_buf.sv
// Self-checking bench for trace_buf: directed scenarios plus randomized traffic
// against a queue-based reference model (two instances: CNT_W=16 and CNT_W=4).
module tb_trace_buf;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, cap_en, if_reg, if_mem, out_ready;
    logic [31:0] pc_now, str_now;

    logic        out_valid, out_valid_4;
    logic [31:0] out_pc, out_pc_4, out_instr, out_instr_4;
    logic [1:0]  out_flags, out_flags_4;
    logic [4:0]  level, level_4;
    logic        overflow, overflow_4;
    logic [15:0] drop_cnt;
    logic [3:0]  drop_cnt_4;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  flags;
    } mrec_t;

    mrec_t q[$];
    int    m_drops = 0;
    bit    m_ovf   = 1'b0;

    trace_buf #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cap_en(cap_en), .pc_now(pc_now), .str_now(str_now),
        .if_reg(if_reg), .if_mem(if_mem), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_flags(out_flags), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    trace_buf #(.DEPTH(DEPTH), .CNT_W(4)) dut_4 (
        .clk(clk), .reset(reset), .cap_en(cap_en), .pc_now(pc_now), .str_now(str_now),
        .if_reg(if_reg), .if_mem(if_mem), .out_valid(out_valid_4), .out_ready(out_ready),
        .out_pc(out_pc_4), .out_instr(out_instr_4), .out_flags(out_flags_4), .level(level_4),
        .overflow(overflow_4), .drop_cnt(drop_cnt_4)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit model_keep(input logic [1:0] fl);
`ifdef TRACE_FILTER_EN
        return fl != 2'b00;
`else
        return fl == fl;
`endif
    endfunction

    function automatic mrec_t exp_head();
        mrec_t h;
        h.pc = 0; h.instr = 0; h.flags = 0;
        if (q.size() != 0) h = q[0];
        return h;
    endfunction

    function automatic int exp_drop(input int w);
        int mx = (1 << w) - 1;
        return (m_drops > mx) ? mx : m_drops;
    endfunction

    task automatic model_edge(input bit cap, input bit rdy, input mrec_t r);
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (cap && model_keep(r.flags)) begin
            if (q.size() < int'(DEPTH)) q.push_back(r);
            else begin
                m_ovf = 1'b1;
                m_drops++;
            end
        end
    endtask

    // One clock: drive at negedge, model updates at posedge, return at next negedge.
    task automatic tick(input bit cap, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [1:0] fl, input bit rdy);
        mrec_t r;
        r.pc = pc; r.instr = ins; r.flags = fl;
        cap_en = cap; pc_now = pc; str_now = ins; if_mem = fl[1]; if_reg = fl[0];
        out_ready = rdy;
        @(posedge clk);
        model_edge(cap, rdy, r);
        @(negedge clk);
        cap_en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_ctl: valid=%0b level=%0d, want 0/0", out_valid, level);
        end
        vectors++;
        if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_flags !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_data: pc=%h instr=%h flags=%b, want zeros", out_pc, out_instr, out_flags);
        end
        vectors++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd0 || drop_cnt_4 !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_acct: ovf=%0b drop=%0d drop4=%0d, want 0", overflow, drop_cnt, drop_cnt_4);
        end
        reset = 1'b1;
        q.delete(); m_drops = 0; m_ovf = 1'b0;
    endtask

    task automatic test_single_stall();
        tick(1'b1, 32'h3000, 32'h3401_0001, 2'b01, 1'b0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instr !== 32'h3401_0001 ||
                out_flags !== 2'b01 || level !== 5'd1) begin
                miscompares++;
                $display("FAIL single_hold[%0d]: valid=%0b pc=%h instr=%h flags=%b level=%0d, want 1/3000/34010001/01/1",
                         i, out_valid, out_pc, out_instr, out_flags, level);
            end
            if (i < 5) tick(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        end
        tick(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0 || out_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL single_drain: valid=%0b level=%0d pc=%h, want 0/0/0", out_valid, level, out_pc);
        end
    endtask

    task automatic test_overflow();
        mrec_t h;
        do_reset();
        for (int i = 0; i < 17; i++)
            tick(1'b1, 32'h3000 + 32'(4 * i), $urandom, 2'b01, 1'b0);
        vectors++;
        if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd1 || drop_cnt_4 !== 4'd1) begin
            miscompares++;
            $display("FAIL ovf_state: level=%0d ovf=%0b drop=%0d drop4=%0d, want 16/1/1/1",
                     level, overflow, drop_cnt, drop_cnt_4);
        end
        for (int i = 0; i < 16; i++) begin
            h = exp_head();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * i) || out_instr !== h.instr) begin
                miscompares++;
                $display("FAIL ovf_drain[%0d]: valid=%0b pc=%h instr=%h, want 1/%h/%h",
                         i, out_valid, out_pc, out_instr, 32'h3000 + 32'(4 * i), h.instr);
            end
            tick(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        end
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL ovf_empty: valid=%0b level=%0d pc=%h, want 0/0", out_valid, level, out_pc);
        end
    endtask

    task automatic test_back_to_back();
        mrec_t h;
        do_reset();
        for (int i = 0; i < 16; i++)
            tick(1'b1, 32'h3000 + 32'(4 * i), $urandom, 2'b10, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 32'h3040 + 32'(4 * k), $urandom, 2'b11, 1'b1);
            h = exp_head();
            vectors++;
            if (level !== 5'd16 || drop_cnt !== 16'd0 || out_pc !== 32'h3000 + 32'(4 * (k + 1)) ||
                out_instr !== h.instr) begin
                miscompares++;
                $display("FAIL b2b[%0d]: level=%0d drop=%0d pc=%h instr=%h, want 16/0/%h/%h",
                         k, level, drop_cnt, out_pc, out_instr, 32'h3000 + 32'(4 * (k + 1)), h.instr);
            end
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'h3028 + 32'(4 * i)) begin
                miscompares++;
                $display("FAIL b2b_drain[%0d]: valid=%0b pc=%h, want 1/%h", i, out_valid, out_pc,
                         32'h3028 + 32'(4 * i));
            end
            tick(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++)
            tick(1'b1, 32'h6000 + 32'(4 * i), $urandom, 2'b01, 1'b0);
        vectors++;
        if (level !== 5'd3 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL async_pre: level=%0d valid=%0b, want 3/1", level, out_valid);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0 || out_pc !== 32'h0 || out_instr !== 32'h0 ||
            out_flags !== 2'b00) begin
            miscompares++;
            $display("FAIL async_clear: valid=%0b level=%0d pc=%h instr=%h flags=%b, want zeros",
                     out_valid, level, out_pc, out_instr, out_flags);
        end
        q.delete(); m_drops = 0; m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
            vectors++;
            if (out_valid !== 1'b0 || level !== 5'd0) begin
                miscompares++;
                $display("FAIL async_stale[%0d]: valid=%0b level=%0d pc=%h, want 0/0", i, out_valid, level, out_pc);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 36; i++)
            tick(1'b1, 32'h4000 + 32'(4 * i), $urandom, 2'b01, 1'b0);
        vectors++;
        if (level !== 5'd16 || overflow !== 1'b1 || overflow_4 !== 1'b1 ||
            drop_cnt !== 16'd20 || drop_cnt_4 !== 4'd15) begin
            miscompares++;
            $display("FAIL sat: level=%0d ovf=%0b ovf4=%0b drop=%0d drop4=%0d, want 16/1/1/20/15",
                     level, overflow, overflow_4, drop_cnt, drop_cnt_4);
        end
        for (int i = 0; i < 16; i++) tick(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        vectors++;
        if (level !== 5'd0 || overflow_4 !== 1'b1 || drop_cnt_4 !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_sticky: level=%0d ovf4=%0b drop4=%0d, want 0/1/15", level, overflow_4, drop_cnt_4);
        end
        do_reset();
        vectors++;
        if (overflow_4 !== 1'b0 || drop_cnt_4 !== 4'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_reset: ovf4=%0b drop4=%0d ovf=%0b, want 0/0/0", overflow_4, drop_cnt_4, overflow);
        end
    endtask

    task automatic test_filter();
        logic [1:0] fls [4];
        mrec_t h;
        int n;
        fls[0] = 2'b00; fls[1] = 2'b01; fls[2] = 2'b10; fls[3] = 2'b00;
        do_reset();
        for (int i = 0; i < 4; i++)
            tick(1'b1, 32'h5000 + 32'(4 * i), $urandom, fls[i], 1'b0);
        n = q.size();
        vectors++;
        if (level !== 5'(n) || drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL filter_level: level=%0d drop=%0d, want %0d/0", level, drop_cnt, n);
        end
        for (int i = 0; i < n; i++) begin
            h = exp_head();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== h.pc || out_flags !== h.flags || out_instr !== h.instr) begin
                miscompares++;
                $display("FAIL filter_out[%0d]: valid=%0b pc=%h flags=%b, want 1/%h/%b",
                         i, out_valid, out_pc, out_flags, h.pc, h.flags);
            end
            tick(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        end
        vectors++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL filter_end: valid=%0b drop=%0d, want 0/0", out_valid, drop_cnt);
        end
    endtask

    task automatic test_random();
        mrec_t h;
        int cap_p, rdy_p;
        bit cap, rdy;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) begin
                cap_p = $urandom_range(20, 100);
                rdy_p = $urandom_range(0, 100);
            end
            cap = ($urandom_range(0, 99) < cap_p);
            rdy = ($urandom_range(0, 99) < rdy_p);
            tick(cap, $urandom, $urandom, 2'($urandom_range(0, 3)), rdy);
            h = exp_head();
            vectors++;
            if (out_valid !== (q.size() != 0) || out_pc !== h.pc || out_instr !== h.instr ||
                out_flags !== h.flags || level !== 5'(q.size()) || overflow !== m_ovf ||
                overflow_4 !== m_ovf || drop_cnt !== 16'(exp_drop(16)) || drop_cnt_4 !== 4'(exp_drop(4))) begin
                miscompares++;
                $display("FAIL random[%0d]: valid=%0b pc=%h instr=%h flags=%b level=%0d ovf=%0b drop=%0d drop4=%0d; want %0b/%h/%h/%b/%0d/%0b/%0d/%0d",
                         c, out_valid, out_pc, out_instr, out_flags, level, overflow, drop_cnt, drop_cnt_4,
                         q.size() != 0, h.pc, h.instr, h.flags, q.size(), m_ovf, exp_drop(16), exp_drop(4));
            end
        end
    endtask

    initial begin
        reset = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
        pc_now = '0; str_now = '0; if_reg = 1'b0; if_mem = 1'b0;
        test_reset();
        test_single_stall();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        test_filter();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
